pcm_to_i2s: RTL and testbench
=============================

# pcm_to_i2s

Serializes parallel 24-bit stereo PCM samples into an I2S master stream (BCLK, LRCK, SDATA) toward the external DAC. It sits directly downstream of the audio source multiplexer and consumes its `l_pcmToI2s_d` / `r_pcmToI2s_d` words and their valid strobes. Each channel is buffered one sample deep, and a complete L/R frame is loaded at every frame boundary. If a channel receives no new sample, the block repeats the last one and flags an underrun.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per BCLK half-period; must be ≥ 2.
- `DATA_WIDTH`, default 24: sample width; must be ≤ 31.
- `SLOT_BITS`, default 32: BCLK periods per channel slot, so a frame is 2·SLOT_BITS periods.

- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `run`  in  1  enable; low forces the idle state, same effect as reset.
- `l_pcmToI2s_d_valid`  in  1  one-cycle strobe: `l_pcmToI2s_d` holds a new left sample.
- `r_pcmToI2s_d_valid`  in  1  one-cycle strobe: `r_pcmToI2s_d` holds a new right sample.
- `l_pcmToI2s_d`  in  DATA_WIDTH  left sample, two's complement.
- `r_pcmToI2s_d`  in  DATA_WIDTH  right sample, two's complement.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `i2s_sdata`  out  1  serial data, MSB first.
- `frame_start`  out  1  one-cycle pulse when a new frame is loaded.
- `underrun`  out  1  one-cycle pulse, concurrent with `frame_start`, when either channel is stale.

## Operation
**Staging registers**
- Each channel has a staging register (`l_stage`, `r_stage`) and a fresh flag.
- A valid strobe writes the sample into that channel's staging register and sets its fresh flag.

**Clock divider**
- `div_cnt` counts 0..CLK_DIV-1.
- At CLK_DIV-1, `i2s_bclk` toggles and `div_cnt` returns to 0.
- A falling edge is the `clk` cycle in which `i2s_bclk` goes 1→0.

**Bit counter**
- `bit_cnt` counts 0..2·SLOT_BITS-1 and advances on each falling edge, wrapping to 0.
- It sits at 2·SLOT_BITS-1 while idle, so the first falling edge after enable wraps it to 0.

**Falling-edge updates** (`i2s_lrclk` and `i2s_sdata` change only here):
- `i2s_lrclk` = (new `bit_cnt` ≥ SLOT_BITS).
- `i2s_sdata` follows the I2S one-bit delay, with k = new `bit_cnt`:
  - k in 1..DATA_WIDTH: left sample bit [DATA_WIDTH-k].
  - k in SLOT_BITS+1..SLOT_BITS+DATA_WIDTH: right sample bit [DATA_WIDTH-(k-SLOT_BITS)].
  - Every other k: 0.

**Frame load** (falling edge where `bit_cnt` wraps to 0):
- Copy `l_stage` and `r_stage` into the frame shift registers.
- Clear both fresh flags.
- Pulse `frame_start`.
- Pulse `underrun` if either fresh flag was 0. The stale channel retransmits its staging value, which is its last sample, or 0 after idle.

**Valid in the load cycle**
- The load uses the staging value from before that cycle.
- The new sample is written to staging and its fresh flag remains 1, so it goes out in the next frame and is not lost.

**Idle** (`reset_n`=0 or `run`=0):
- `div_cnt`=0, `bit_cnt`=2·SLOT_BITS-1.
- Staging registers and shift registers = 0; fresh flags = 0.
- All outputs = 0.
- Valid strobes are ignored.
- Dropping `run` or `reset_n` mid-frame takes effect on the next `clk` edge. The partial frame is abandoned; no completion is attempted.

## Timing
- Reset value of every output is 0.
- BCLK period = 2·CLK_DIV `clk` cycles; frame = 4·SLOT_BITS·CLK_DIV cycles (default 512).
- First `i2s_bclk` rising edge: CLK_DIV cycles after the first non-idle cycle.
- First falling edge and first `frame_start`: 2·CLK_DIV cycles after the first non-idle cycle.
- `i2s_sdata` and `i2s_lrclk` are stable for a full BCLK period around each rising edge, which is where the DAC samples.
- Latency from a valid strobe to that sample's MSB on `i2s_sdata`: at most one frame plus one BCLK period.
- `frame_start` and `underrun` assert in the same `clk` cycle as the BCLK falling edge that loads the frame.

## Test plan
- **Basic frame:** reset, run=1, one strobe each with L=24'hA5A5A5, R=24'h3C3C3C before the second frame_start → the second frame carries MSB-first 101001011010010110100101 in BCLK periods 1–24 and 001111000011110000111100 in periods 33–56; zeros elsewhere; lrclk toggles at periods 0 and 32.
- **Startup timing:** CLK_DIV=4 → the first bclk rise is 4 cycles and the first frame_start 8 cycles after run goes high; the bclk period is 8 clk cycles; frame_start repeats every 512 cycles.
- **Underrun:** supply only a left sample (24'h000001) before a frame boundary → underrun pulses with frame_start; the right slot repeats the previous right value; left LSB=1 appears in BCLK period 24.
- **Collision:** assert l/r valid (24'h7FFFFF) in the exact frame_start cycle → that frame carries the old staging values; the next frame carries 24'h7FFFFF with no underrun.
- **Mid-frame abort:** drop run at BCLK period 40 → all outputs are 0 on the next cycle; re-raise run → restart per the startup timing, with the first frame all zeros and underrun=1.
- **Sync reset vs run:** assert reset_n=0 for 1 cycle during streaming → identical behaviour to the run-drop case.

Source files
------------

// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s
// ----------
// Serializes parallel stereo PCM samples into an I2S master stream
// (BCLK, LRCK, SDATA). Each channel is buffered one sample deep in a staging
// register; a full L/R frame is copied into the frame shift registers at
// every frame boundary. A channel that received no new sample since the last
// boundary retransmits its staging value and raises a one-cycle underrun.
//
// Handshake: the *_valid inputs are one-cycle strobes with no ready. A strobe
// is accepted unconditionally whenever the block is running. If several
// strobes arrive within one frame, the last one wins. While idle (reset_n=0
// or run=0), strobes are ignored.
//
// Ports
//   clk                 in   system clock (only clock)
//   reset_n             in   synchronous active-low reset
//   run                 in   enable; low forces idle, same as reset
//   l/r_pcmToI2s_d_valid in  one-cycle "new sample" strobes
//   l/r_pcmToI2s_d      in   DATA_WIDTH two's complement samples
//   i2s_bclk            out  bit clock (CLK_DIV clk cycles per half period)
//   i2s_lrclk           out  word select, 0 = left slot, 1 = right slot
//   i2s_sdata           out  serial data, MSB first, one BCLK after LRCK edge
//   frame_start         out  one-cycle pulse when a new frame is loaded
//   underrun            out  pulse with frame_start when a channel is stale
module pcm_to_i2s #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  l_pcmToI2s_d_valid,
  input  logic                  r_pcmToI2s_d_valid,
  input  logic [DATA_WIDTH-1:0] l_pcmToI2s_d,
  input  logic [DATA_WIDTH-1:0] r_pcmToI2s_d,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] L_FIRST    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] R_FIRST    = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(SLOT_BITS + DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] l_stage_q, l_stage_d;
  logic [DATA_WIDTH-1:0] r_stage_q, r_stage_d;
  logic                  l_fresh_q, l_fresh_d;
  logic                  r_fresh_q, r_fresh_d;
  logic [DATA_WIDTH-1:0] l_shift_q, l_shift_d;
  logic [DATA_WIDTH-1:0] r_shift_q, r_shift_d;

  logic                  div_tick;
  logic                  bclk_fall;
  logic [CNT_W-1:0]      bit_nxt;

  always_comb begin
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    l_stage_d     = l_stage_q;
    r_stage_d     = r_stage_q;
    l_fresh_d     = l_fresh_q;
    r_fresh_d     = r_fresh_q;
    l_shift_d     = l_shift_q;
    r_shift_d     = r_shift_q;
    div_tick      = 1'b0;
    bclk_fall     = 1'b0;
    bit_nxt       = '0;

    if (!run) begin
      // Idle: bit_cnt parks at the last bit so the first falling edge after
      // enable wraps to 0 and loads a frame.
      div_cnt_d = '0;
      bit_cnt_d = BIT_LAST;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      l_stage_d = '0;
      r_stage_d = '0;
      l_fresh_d = 1'b0;
      r_fresh_d = 1'b0;
      l_shift_d = '0;
      r_shift_d = '0;
    end else begin
      div_tick  = (div_cnt_q == DIV_LAST);
      div_cnt_d = div_tick ? '0 : div_cnt_q + 1'b1;
      if (div_tick) begin
        bclk_d = ~bclk_q;
      end
      bclk_fall = div_tick && bclk_q;

      if (bclk_fall) begin
        bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        bit_cnt_d = bit_nxt;
        lrclk_d   = (bit_nxt >= SLOT_START);
        sdata_d   = 1'b0;
        if (bit_nxt == '0) begin
          // Frame boundary: staging values from before this cycle are used.
          l_shift_d     = l_stage_q;
          r_shift_d     = r_stage_q;
          l_fresh_d     = 1'b0;
          r_fresh_d     = 1'b0;
          frame_start_d = 1'b1;
          underrun_d    = !(l_fresh_q && r_fresh_q);
        end else if (bit_nxt >= L_FIRST && bit_nxt <= L_LAST) begin
          sdata_d   = l_shift_q[DATA_WIDTH-1];
          l_shift_d = l_shift_q << 1;
        end else if (bit_nxt >= R_FIRST && bit_nxt <= R_LAST) begin
          sdata_d   = r_shift_q[DATA_WIDTH-1];
          r_shift_d = r_shift_q << 1;
        end
      end

      // Placed after the frame load so a strobe in the load cycle keeps its
      // fresh flag and is carried by the following frame.
      if (l_pcmToI2s_d_valid) begin
        l_stage_d = l_pcmToI2s_d;
        l_fresh_d = 1'b1;
      end
      if (r_pcmToI2s_d_valid) begin
        r_stage_d = r_pcmToI2s_d;
        r_fresh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_LAST;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      l_stage_q     <= '0;
      r_stage_q     <= '0;
      l_fresh_q     <= 1'b0;
      r_fresh_q     <= 1'b0;
      l_shift_q     <= '0;
      r_shift_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      l_stage_q     <= l_stage_d;
      r_stage_q     <= r_stage_d;
      l_fresh_q     <= l_fresh_d;
      r_fresh_q     <= r_fresh_d;
      l_shift_q     <= l_shift_d;
      r_shift_q     <= r_shift_d;
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s
// -------------
// Bench for pcm_to_i2s. A reference model counts clk cycles since enable and,
// at each frame boundary, pushes {underrun, left, right} for the frame that
// must go out. A monitor on the falling clk edge pops an entry on every
// frame_start and collects SDATA/LRCK at each BCLK rising edge, comparing the
// whole frame once all 2*SLOT_BITS periods have been seen.
module tb_pcm_to_i2s;

  localparam int CLK_DIV   = 4;
  localparam int DW        = 24;
  localparam int SB        = 32;
  localparam int FRAME_CYC = 4 * SB * CLK_DIV;
  localparam int LOAD_N    = 2 * CLK_DIV;
  localparam int EW        = 2 * DW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          l_valid = 1'b0;
  logic          r_valid = 1'b0;
  logic [DW-1:0] l_d = '0;
  logic [DW-1:0] r_d = '0;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

  always #5 clk = ~clk;

  pcm_to_i2s #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .SLOT_BITS(SB)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .run                (run),
    .l_pcmToI2s_d_valid (l_valid),
    .r_pcmToI2s_d_valid (r_valid),
    .l_pcmToI2s_d       (l_d),
    .r_pcmToI2s_d       (r_d),
    .i2s_bclk           (i2s_bclk),
    .i2s_lrclk          (i2s_lrclk),
    .i2s_sdata          (i2s_sdata),
    .frame_start        (frame_start),
    .underrun           (underrun)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int frames_checked = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*SB-1:0] frame_bits(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [2*SB-1:0] v;
    v = '0;
    // Period k of the left slot carries bit DW-k; the right slot likewise.
    for (int k = 1; k <= DW; k++) begin
      v[2*SB-1-k] = l[DW-k];
      v[SB-1-k]   = r[DW-k];
    end
    return v;
  endfunction

  // ---------------- reference model ----------------
  // n = number of clk cycles elapsed since the first non-idle cycle.
  int            n = 0;
  bit            exp_idle = 1'b1;
  bit            exp_fs = 1'b0;
  bit            exp_bclk = 1'b0;
  logic [DW-1:0] m_l = '0, m_r = '0;
  bit            m_fl = 1'b0, m_fr = 1'b0;

  always @(posedge clk) begin
    if (!reset_n || !run) begin
      n = 0; exp_idle = 1'b1; exp_fs = 1'b0; exp_bclk = 1'b0;
      m_l = '0; m_r = '0; m_fl = 1'b0; m_fr = 1'b0;
    end else begin
      n = n + 1;
      exp_idle = 1'b0;
      exp_bclk = ((n / CLK_DIV) % 2) == 1;
      exp_fs   = (n % FRAME_CYC) == LOAD_N;
      if (exp_fs) begin
        exp_q.push_back({!(m_fl && m_fr), m_l, m_r});
        m_fl = 1'b0; m_fr = 1'b0;
      end
      if (l_valid) begin m_l = l_d; m_fl = 1'b1; end
      if (r_valid) begin m_r = r_d; m_fr = 1'b1; end
    end
  end

  // ---------------- monitor ----------------
  logic [EW-1:0]   cur;
  bit              collecting = 1'b0;
  bit              prev_bclk = 1'b0;
  int              cnt = 0;
  logic [2*SB-1:0] cap_sd, cap_lr;

  always @(negedge clk) begin
    if (exp_idle) begin
      check("idle_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun}, 5'b0);
      collecting = 1'b0;
      prev_bclk  = 1'b0;
    end else begin
      check("bclk_fs_timing", {i2s_bclk, frame_start, underrun & ~frame_start},
            {exp_bclk, exp_fs, 1'b0});
      if (frame_start) begin
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("underrun", underrun, cur[EW-1]);
          collecting = 1'b1;
          cnt = 0;
          cap_sd = '0;
          cap_lr = '0;
        end
      end
      if (collecting && i2s_bclk && !prev_bclk) begin
        cap_sd[2*SB-1-cnt] = i2s_sdata;
        cap_lr[2*SB-1-cnt] = i2s_lrclk;
        cnt++;
        if (cnt == 2 * SB) begin
          check("frame_sdata", cap_sd, frame_bits(cur[2*DW-1:DW], cur[DW-1:0]));
          check("frame_lrclk", cap_lr, {{SB{1'b0}}, {SB{1'b1}}});
          frames_checked++;
          collecting = 1'b0;
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    l_valid = 1'b0;
    r_valid = 1'b0;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic strobe(input bit do_l, input logic [DW-1:0] lv,
                        input bit do_r, input logic [DW-1:0] rv);
    l_valid = do_l; l_d = lv;
    r_valid = do_r; r_d = rv;
    step();
  endtask

  // Waits until the model's cycle count within the frame equals ph; a strobe
  // issued right after is sampled at the edge that makes it ph+1.
  task automatic wait_phase(input int ph);
    int guard;
    guard = 0;
    while ((n % FRAME_CYC) != ph && guard < FRAME_CYC + 4) begin
      step();
      guard++;
    end
    check("wait_phase", n % FRAME_CYC, ph);
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 199) == 0) begin l_valid = 1'b1; l_d = DW'($urandom); end
      if ($urandom_range(0, 199) == 0) begin r_valid = 1'b1; r_d = DW'($urandom); end
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; run = 1'b0;
    steps(4);
    reset_n = 1'b1;
    steps(3);
    // Strobes while idle must be ignored.
    strobe(1'b1, 24'h123456, 1'b1, 24'h654321);
    steps(2);

    // Startup; first frame is all zeros with underrun.
    run = 1'b1;
    wait_phase(100);
    strobe(1'b1, 24'hA5A5A5, 1'b1, 24'h3C3C3C);   // basic frame
    wait_phase(100);
    strobe(1'b1, 24'h000001, 1'b0, '0);           // right channel stale
    wait_phase(LOAD_N - 1);
    strobe(1'b1, 24'h7FFFFF, 1'b1, 24'h7FFFFF);   // collides with frame load
    wait_phase(100);
    run_random(6 * FRAME_CYC);

    // Mid-frame abort at BCLK period 40, then restart.
    wait_phase(LOAD_N + 2 * CLK_DIV * 40 + CLK_DIV);
    run = 1'b0;
    steps(3);
    run = 1'b1;
    wait_phase(200);
    strobe(1'b1, DW'($urandom), 1'b1, DW'($urandom));
    run_random(2 * FRAME_CYC);

    // One-cycle synchronous reset mid-stream.
    wait_phase(300);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    wait_phase(150);
    strobe(1'b1, DW'($urandom), 1'b1, DW'($urandom));
    run_random(2 * FRAME_CYC + 100);

    run = 1'b0;
    steps(5);
    check("sb_drained", exp_q.size(), 0);
    check("frames_seen", frames_checked >= 12, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
